vga_timing_dual_mode: RTL and testbench



---
 rtl/vga_timing_dual_mode.sv | 199 +++++++++++++++++++
 tb/tb_vga_timing_dual_mode.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_dual_mode.sv
// Purpose: VGA-style raster timing generator with two parameterised timing sets, switched only at frame boundaries.
// Latency: every level output is registered from the next counter values, so it lines up with the counts it is shown with.
// Backpressure: i_pix_en gates every advance; when it is low, the counters and levels hold and the strobes stay low.
module vga_timing_dual_mode #(
  parameter int   HW     = 11,
  parameter int   VW     = 10,
  parameter int   FW     = 8,
  parameter int   A_HACT = 640,
  parameter int   A_HFP  = 16,
  parameter int   A_HSP  = 96,
  parameter int   A_HBP  = 48,
  parameter int   A_VACT = 480,
  parameter int   A_VFP  = 10,
  parameter int   A_VSP  = 2,
  parameter int   A_VBP  = 33,
  parameter logic A_HPOL = 1'b0,
  parameter logic A_VPOL = 1'b0,
  parameter int   B_HACT = 800,
  parameter int   B_HFP  = 40,
  parameter int   B_HSP  = 128,
  parameter int   B_HBP  = 88,
  parameter int   B_VACT = 600,
  parameter int   B_VFP  = 1,
  parameter int   B_VSP  = 4,
  parameter int   B_VBP  = 23,
  parameter logic B_HPOL = 1'b1,
  parameter logic B_VPOL = 1'b1
) (
  input  logic          i_core_clk,
  input  logic          i_arst_n,
  input  logic          i_pix_en,
  input  logic          i_mode_sel,
  output logic [HW-1:0] o_pixel_cnt,
  output logic [VW-1:0] o_line_cnt,
  output logic          o_h_sync,
  output logic          o_v_sync,
  output logic          o_h_blank,
  output logic          o_v_blank,
  output logic          o_comp_blank,
  output logic          o_disp_en,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_active_mode,
  output logic [FW-1:0] o_frame_cnt
);

  // Frame totals per timing set
  localparam int A_HTOT = A_HACT + A_HFP + A_HSP + A_HBP;
  localparam int A_VTOT = A_VACT + A_VFP + A_VSP + A_VBP;
  localparam int B_HTOT = B_HACT + B_HFP + B_HSP + B_HBP;
  localparam int B_VTOT = B_VACT + B_VFP + B_VSP + B_VBP;

  // Horizontal decode points sized to the pixel counter
  localparam logic [HW-1:0] A_HLAST   = HW'(A_HTOT - 1);
  localparam logic [HW-1:0] A_HACT_W  = HW'(A_HACT);
  localparam logic [HW-1:0] A_HS_BEG  = HW'(A_HACT + A_HFP);
  localparam logic [HW-1:0] A_HS_END  = HW'(A_HACT + A_HFP + A_HSP);
  localparam logic [HW-1:0] B_HLAST   = HW'(B_HTOT - 1);
  localparam logic [HW-1:0] B_HACT_W  = HW'(B_HACT);
  localparam logic [HW-1:0] B_HS_BEG  = HW'(B_HACT + B_HFP);
  localparam logic [HW-1:0] B_HS_END  = HW'(B_HACT + B_HFP + B_HSP);

  // Vertical decode points sized to the line counter
  localparam logic [VW-1:0] A_VLAST   = VW'(A_VTOT - 1);
  localparam logic [VW-1:0] A_VACT_W  = VW'(A_VACT);
  localparam logic [VW-1:0] A_VS_BEG  = VW'(A_VACT + A_VFP);
  localparam logic [VW-1:0] A_VS_END  = VW'(A_VACT + A_VFP + A_VSP);
  localparam logic [VW-1:0] B_VLAST   = VW'(B_VTOT - 1);
  localparam logic [VW-1:0] B_VACT_W  = VW'(B_VACT);
  localparam logic [VW-1:0] B_VS_BEG  = VW'(B_VACT + B_VFP);
  localparam logic [VW-1:0] B_VS_END  = VW'(B_VACT + B_VFP + B_VSP);

  // State
  logic [HW-1:0] r_pixel_cnt;
  logic [VW-1:0] r_line_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic          r_mode;
  logic          r_h_sync;
  logic          r_v_sync;
  logic          r_h_blank;
  logic          r_v_blank;
  logic          r_comp_blank;
  logic          r_disp_en;
  logic          r_line_start;
  logic          r_frame_start;

  // Wrap detection uses the timing set of the frame in progress
  logic [HW-1:0] w_h_last;
  logic [VW-1:0] w_v_last;
  logic          w_h_wrap;
  logic          w_frame_wrap;

  assign w_h_last     = r_mode ? B_HLAST : A_HLAST;
  assign w_v_last     = r_mode ? B_VLAST : A_VLAST;
  assign w_h_wrap     = (r_pixel_cnt == w_h_last);
  assign w_frame_wrap = w_h_wrap && (r_line_cnt == w_v_last);

  // Next counter values and next timing set (mode only moves on the frame wrap)
  logic [HW-1:0] w_pixel_nxt;
  logic [VW-1:0] w_line_nxt;
  logic          w_mode_nxt;

  assign w_pixel_nxt = w_h_wrap ? '0 : (r_pixel_cnt + HW'(1));
  assign w_line_nxt  = w_frame_wrap ? '0 :
                       w_h_wrap     ? (r_line_cnt + VW'(1)) : r_line_cnt;
  assign w_mode_nxt  = w_frame_wrap ? i_mode_sel : r_mode;

  // Decode points of the timing set that will own the next counts, so a
  // switch at the wrap drives the new mode's levels from count (0,0) onward
  logic [HW-1:0] w_n_hact;
  logic [HW-1:0] w_n_hs_beg;
  logic [HW-1:0] w_n_hs_end;
  logic [VW-1:0] w_n_vact;
  logic [VW-1:0] w_n_vs_beg;
  logic [VW-1:0] w_n_vs_end;
  logic          w_n_hpol;
  logic          w_n_vpol;

  assign w_n_hact   = w_mode_nxt ? B_HACT_W : A_HACT_W;
  assign w_n_hs_beg = w_mode_nxt ? B_HS_BEG : A_HS_BEG;
  assign w_n_hs_end = w_mode_nxt ? B_HS_END : A_HS_END;
  assign w_n_vact   = w_mode_nxt ? B_VACT_W : A_VACT_W;
  assign w_n_vs_beg = w_mode_nxt ? B_VS_BEG : A_VS_BEG;
  assign w_n_vs_end = w_mode_nxt ? B_VS_END : A_VS_END;
  assign w_n_hpol   = w_mode_nxt ? B_HPOL : A_HPOL;
  assign w_n_vpol   = w_mode_nxt ? B_VPOL : A_VPOL;

  // Level decodes of the next position
  logic w_h_win;
  logic w_v_win;
  logic w_h_blank_nxt;
  logic w_v_blank_nxt;

  assign w_h_win       = (w_pixel_nxt >= w_n_hs_beg) && (w_pixel_nxt < w_n_hs_end);
  assign w_v_win       = (w_line_nxt >= w_n_vs_beg) && (w_line_nxt < w_n_vs_end);
  assign w_h_blank_nxt = (w_pixel_nxt >= w_n_hact);
  assign w_v_blank_nxt = (w_line_nxt >= w_n_vact);

  // Raster counters, active mode and completed-frame count
  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_pixel_cnt <= '0;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
      r_mode      <= 1'b0;
    end else if (i_pix_en) begin
      r_pixel_cnt <= w_pixel_nxt;
      r_line_cnt  <= w_line_nxt;
      r_mode      <= w_mode_nxt;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  // Registered sync/blank levels decoded from the next counts
  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_h_sync     <= ~A_HPOL;
      r_v_sync     <= ~A_VPOL;
      r_h_blank    <= 1'b0;
      r_v_blank    <= 1'b0;
      r_comp_blank <= 1'b0;
      r_disp_en    <= 1'b1;
    end else if (i_pix_en) begin
      r_h_sync     <= w_h_win ? w_n_hpol : ~w_n_hpol;
      r_v_sync     <= w_v_win ? w_n_vpol : ~w_n_vpol;
      r_h_blank    <= w_h_blank_nxt;
      r_v_blank    <= w_v_blank_nxt;
      r_comp_blank <= w_h_blank_nxt | w_v_blank_nxt;
      r_disp_en    <= ~(w_h_blank_nxt | w_v_blank_nxt);
    end
  end

  // One-clock line/frame start strobes, low on any non-advancing clock
  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= i_pix_en & w_h_wrap;
      r_frame_start <= i_pix_en & w_frame_wrap;
    end
  end

  assign o_pixel_cnt   = r_pixel_cnt;
  assign o_line_cnt    = r_line_cnt;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_active_mode = r_mode;
  assign o_h_sync      = r_h_sync;
  assign o_v_sync      = r_v_sync;
  assign o_h_blank     = r_h_blank;
  assign o_v_blank     = r_v_blank;
  assign o_comp_blank  = r_comp_blank;
  assign o_disp_en     = r_disp_en;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_dual_mode.sv
// Bench for vga_timing_dual_mode using reduced raster sizes so whole frames run quickly.
// Mode A: 15x10 raster (hsync 10..12 active-low, vsync 7..8 active-low); mode B: 20x14 (hsync 13..16, vsync 9..11, active-high).
// Frame counter is 2 bits wide to exercise its wrap.
module tb_vga_timing_dual_mode;

  localparam int HW = 11;
  localparam int VW = 10;
  localparam int FW = 2;

  localparam int T_A_HACT = 8;
  localparam int T_A_HFP  = 2;
  localparam int T_A_HSP  = 3;
  localparam int T_A_HBP  = 2;
  localparam int T_A_VACT = 6;
  localparam int T_A_VFP  = 1;
  localparam int T_A_VSP  = 2;
  localparam int T_A_VBP  = 1;
  localparam int T_B_HACT = 10;
  localparam int T_B_HFP  = 3;
  localparam int T_B_HSP  = 4;
  localparam int T_B_HBP  = 3;
  localparam int T_B_VACT = 8;
  localparam int T_B_VFP  = 1;
  localparam int T_B_VSP  = 3;
  localparam int T_B_VBP  = 2;

  bit clk = 1'b0;
  logic arst_n;
  logic pix_en;
  logic mode_sel;
  logic [HW-1:0] pixel_cnt;
  logic [VW-1:0] line_cnt;
  logic [FW-1:0] frame_cnt;
  logic h_sync, v_sync, h_blank, v_blank, comp_blank, disp_en;
  logic line_start, frame_start, active_mode;

  int total = 0;
  int bad   = 0;

  // Reference model state: raster position, mode, frames, strobes
  int m_x, m_y, m_mode, m_frames, m_ls, m_fs;

  always #5 clk = ~clk;

  vga_timing_dual_mode #(
    .HW(HW), .VW(VW), .FW(FW),
    .A_HACT(T_A_HACT), .A_HFP(T_A_HFP), .A_HSP(T_A_HSP), .A_HBP(T_A_HBP),
    .A_VACT(T_A_VACT), .A_VFP(T_A_VFP), .A_VSP(T_A_VSP), .A_VBP(T_A_VBP),
    .A_HPOL(1'b0), .A_VPOL(1'b0),
    .B_HACT(T_B_HACT), .B_HFP(T_B_HFP), .B_HSP(T_B_HSP), .B_HBP(T_B_HBP),
    .B_VACT(T_B_VACT), .B_VFP(T_B_VFP), .B_VSP(T_B_VSP), .B_VBP(T_B_VBP),
    .B_HPOL(1'b1), .B_VPOL(1'b1)
  ) dut (
    .i_core_clk   (clk),
    .i_arst_n     (arst_n),
    .i_pix_en     (pix_en),
    .i_mode_sel   (mode_sel),
    .o_pixel_cnt  (pixel_cnt),
    .o_line_cnt   (line_cnt),
    .o_h_sync     (h_sync),
    .o_v_sync     (v_sync),
    .o_h_blank    (h_blank),
    .o_v_blank    (v_blank),
    .o_comp_blank (comp_blank),
    .o_disp_en    (disp_en),
    .o_line_start (line_start),
    .o_frame_start(frame_start),
    .o_active_mode(active_mode),
    .o_frame_cnt  (frame_cnt)
  );

  function automatic int hact(int m); return (m != 0) ? T_B_HACT : T_A_HACT; endfunction
  function automatic int hsb(int m);  return (m != 0) ? T_B_HACT + T_B_HFP : T_A_HACT + T_A_HFP; endfunction
  function automatic int hsp(int m);  return (m != 0) ? T_B_HSP : T_A_HSP; endfunction
  function automatic int htot(int m);
    return (m != 0) ? T_B_HACT + T_B_HFP + T_B_HSP + T_B_HBP : T_A_HACT + T_A_HFP + T_A_HSP + T_A_HBP;
  endfunction
  function automatic int vact(int m); return (m != 0) ? T_B_VACT : T_A_VACT; endfunction
  function automatic int vsb(int m);  return (m != 0) ? T_B_VACT + T_B_VFP : T_A_VACT + T_A_VFP; endfunction
  function automatic int vsp(int m);  return (m != 0) ? T_B_VSP : T_A_VSP; endfunction
  function automatic int vtot(int m);
    return (m != 0) ? T_B_VACT + T_B_VFP + T_B_VSP + T_B_VBP : T_A_VACT + T_A_VFP + T_A_VSP + T_A_VBP;
  endfunction
  // Sync level: polarity inside the window, its complement outside
  function automatic int sync_lvl(int pos, int beg, int len, int pol);
    return (pos >= beg && pos < beg + len) ? pol : 1 - pol;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_mode = 0; m_frames = 0; m_ls = 0; m_fs = 0;
  endtask

  // One clock of the raster rules applied to the model
  task automatic model_step(input bit en, input bit sel);
    m_ls = 0;
    m_fs = 0;
    if (en) begin
      if (m_x == htot(m_mode) - 1) begin
        m_x  = 0;
        m_ls = 1;
        if (m_y == vtot(m_mode) - 1) begin
          m_y      = 0;
          m_fs     = 1;
          m_frames = (m_frames + 1) % (1 << FW);
          m_mode   = sel;
        end else begin
          m_y++;
        end
      end else begin
        m_x++;
      end
    end
  endtask

  task automatic check_model();
    int hb, vb;
    hb = (m_x >= hact(m_mode)) ? 1 : 0;
    vb = (m_y >= vact(m_mode)) ? 1 : 0;
    check("pix",    32'(pixel_cnt),   m_x);
    check("line",   32'(line_cnt),    m_y);
    check("mode",   32'(active_mode), m_mode);
    check("fcnt",   32'(frame_cnt),   m_frames);
    check("hsync",  32'(h_sync),      sync_lvl(m_x, hsb(m_mode), hsp(m_mode), m_mode));
    check("vsync",  32'(v_sync),      sync_lvl(m_y, vsb(m_mode), vsp(m_mode), m_mode));
    check("hblank", 32'(h_blank),     hb);
    check("vblank", 32'(v_blank),     vb);
    check("cblank", 32'(comp_blank),  hb | vb);
    check("disp",   32'(disp_en),     1 - (hb | vb));
    check("lstart", 32'(line_start),  m_ls);
    check("fstart", 32'(frame_start), m_fs);
  endtask

  // Drive inputs, take one edge, sample 1 time unit later, advance the model
  task automatic tick(input bit en, input bit sel);
    pix_en   = en;
    mode_sel = sel;
    @(posedge clk);
    #1;
    model_step(en, sel);
  endtask

  // Advance with pixEn=1 until the model reaches (tx,ty), checking every clock
  task automatic walk_to(input int tx, input int ty, input bit sel, input string tag);
    int n;
    n = 0;
    while (!(m_x == tx && m_y == ty) && n < 2000) begin
      tick(1'b1, sel);
      check_model();
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: model at (%0d,%0d) required (%0d,%0d)", tag, m_x, m_y, tx, ty);
    end
    check({tag, "_x"}, 32'(pixel_cnt), tx);
    check({tag, "_y"}, 32'(line_cnt), ty);
  endtask

  typedef struct {
    bit en;
    int pix;
    int line;
    bit hs;
    bit hb;
    bit ls;
    bit de;
  } vec_t;

  vec_t vecs [19];
  int   fexp [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Mode A after reset, first line: hsync window 10..12 (active low), hblank from 8
    vecs[0]  = '{1'b1,  1, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0,  1, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1,  2, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1,  3, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1,  4, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1,  5, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1,  6, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1,  7, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1,  8, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1,  9, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 11, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 12, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 13, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 14, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b1,  0, 1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b0,  0, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{1'b1,  1, 1, 1'b1, 1'b0, 1'b0, 1'b1};
    fexp = '{1, 2, 3, 0, 1};

    arst_n   = 1'b0;
    pix_en   = 1'b0;
    mode_sel = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix",   32'(pixel_cnt),   0);
    check("rst_line",  32'(line_cnt),    0);
    check("rst_fcnt",  32'(frame_cnt),   0);
    check("rst_mode",  32'(active_mode), 0);
    check("rst_hsync", 32'(h_sync),      1);
    check("rst_vsync", 32'(v_sync),      1);
    check("rst_hblank",32'(h_blank),     0);
    check("rst_vblank",32'(v_blank),     0);
    check("rst_cblank",32'(comp_blank),  0);
    check("rst_disp",  32'(disp_en),     1);
    check("rst_lstart",32'(line_start),  0);
    check("rst_fstart",32'(frame_start), 0);
    arst_n = 1'b1;

    // First line of mode A from the vector table
    for (int i = 0; i < 19; i++) begin
      tick(vecs[i].en, 1'b0);
      check($sformatf("vec%0d_pix", i),  32'(pixel_cnt),  vecs[i].pix);
      check($sformatf("vec%0d_line", i), 32'(line_cnt),   vecs[i].line);
      check($sformatf("vec%0d_hs", i),   32'(h_sync),     32'(vecs[i].hs));
      check($sformatf("vec%0d_hb", i),   32'(h_blank),    32'(vecs[i].hb));
      check($sformatf("vec%0d_ls", i),   32'(line_start), 32'(vecs[i].ls));
      check($sformatf("vec%0d_de", i),   32'(disp_en),    32'(vecs[i].de));
    end

    // Five frame wraps with a 2-bit frame counter
    for (int f = 0; f < 5; f++) begin
      tick(1'b1, 1'b0);
      check_model();
      walk_to(0, 0, 1'b0, "frame");
      check($sformatf("fcnt%0d", f),   32'(frame_cnt),   fexp[f]);
      check($sformatf("fstart%0d", f), 32'(frame_start), 1);
      check($sformatf("lstart%0d", f), 32'(line_start),  1);
    end
    tick(1'b1, 1'b0);
    check("fstart_width", 32'(frame_start), 0);
    check("lstart_width", 32'(line_start),  0);

    // Mode request mid-frame is ignored until the frame wrap
    walk_to(0, 3, 1'b0, "sw_line3");
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      check("sw_mid_mode", 32'(active_mode), 0);
    end
    tick(1'b1, 1'b0);
    check("sw_mid_mode0", 32'(active_mode), 0);
    walk_to(14, 9, 1'b1, "sw_last");
    check("sw_pre_mode",  32'(active_mode), 0);
    check("sw_pre_hsync", 32'(h_sync),      1);
    tick(1'b1, 1'b1);
    check("sw_mode",   32'(active_mode), 1);
    check("sw_pix",    32'(pixel_cnt),   0);
    check("sw_line",   32'(line_cnt),    0);
    check("sw_hsync",  32'(h_sync),      0);
    check("sw_vsync",  32'(v_sync),      0);
    check("sw_fstart", 32'(frame_start), 1);
    walk_to(13, 0, 1'b1, "b_hs_on");
    check("b_hsync_13", 32'(h_sync), 1);
    walk_to(17, 0, 1'b1, "b_hs_off");
    check("b_hsync_17", 32'(h_sync), 0);
    walk_to(19, 0, 1'b1, "b_hlast");
    tick(1'b1, 1'b1);
    check("b_hwrap_pix",  32'(pixel_cnt), 0);
    check("b_hwrap_line", 32'(line_cnt),  1);
    walk_to(0, 9, 1'b1, "b_vs_on");
    check("b_vsync_9", 32'(v_sync), 1);
    walk_to(0, 12, 1'b1, "b_vs_off");
    check("b_vsync_12", 32'(v_sync), 0);

    // Asynchronous reset in the middle of a mode B frame
    walk_to(15, 10, 1'b1, "rst_pos");
    check("pre_rst_hblank", 32'(h_blank), 1);
    #2 arst_n = 1'b0;
    #1;
    check("arst_pix",    32'(pixel_cnt),   0);
    check("arst_line",   32'(line_cnt),    0);
    check("arst_mode",   32'(active_mode), 0);
    check("arst_hsync",  32'(h_sync),      1);
    check("arst_vsync",  32'(v_sync),      1);
    check("arst_hblank", 32'(h_blank),     0);
    check("arst_disp",   32'(disp_en),     1);
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold_pix", 32'(pixel_cnt), 0);
    arst_n = 1'b1;
    tick(1'b1, 1'b1);
    check("post_rst_pix",  32'(pixel_cnt),   1);
    check("post_rst_mode", 32'(active_mode), 0);
    check_model();

    // Randomised enable and mode requests against the model
    mode_sel = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit en, sel;
      en  = ($urandom_range(0, 9) < 7);
      sel = mode_sel;
      if ($urandom_range(0, 99) < 2) sel = ~sel;
      tick(en, sel);
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
